// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared widths, load_op encodings and bus field offsets for
//                the MEM stage and its load-data extraction logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    // Opaque CSR field {csr_num[13:0], csr_we, csr_wvalue[31:0], csr_wmask[31:0]}
    localparam int CSR_W = 79;
    localparam int EM_W  = 75 + CSR_W;
    localparam int MW_W  = 103 + CSR_W;
    localparam int FWD_W = 39;

    // load_op encodings
    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    // EX->MEM bus: {pc, gr_we, dest, alu_result, load_op, rfrom_mem, mem_req, csr}
    // Offsets are counted from the bit just above the CSR field so that the
    // layout stays valid for any CSR width.
    localparam int EM_MEM_REQ = 0;
    localparam int EM_RFROM   = 1;
    localparam int EM_LOAD_OP = 2;
    localparam int EM_ALU     = 5;
    localparam int EM_DEST    = 37;
    localparam int EM_GR_WE   = 42;
    localparam int EM_PC      = 43;

    // Forwarding bus: {dest[4:0], is_load, data_pending, fwd_result[31:0]}
    localparam int FWD_DEST    = 34;
    localparam int FWD_IS_LOAD = 33;
    localparam int FWD_PENDING = 32;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_stage_load_extract.sv
`default_nettype none
// ============================================================================
//  Module      : load_extract
//  Description : Selects the addressed byte/half/word out of a 32-bit memory
//                read word and sign- or zero-extends it according to load_op.
//                Purely combinational; shared with the cache refill path.
//  Ports       : i_load_op [2:0]  - load type (LD_B/LD_H/LD_W/LD_BU/LD_HU)
//                i_addr_lo [1:0]  - low address bits selecting byte/half
//                i_rdata   [31:0] - raw memory word
//                o_result  [31:0] - extended load value
//  Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_load_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    // Halfword loads are always aligned, so only bit 1 selects the half.
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_result = i_rdata;
        case (i_load_op)
            LD_B:    o_result = {{24{w_byte[7]}}, w_byte};
            LD_H:    o_result = {{16{w_half[15]}}, w_half};
            LD_BU:   o_result = {24'h000000, w_byte};
            LD_HU:   o_result = {16'h0000, w_half};
            // LD_W and undefined encodings return the full word
            default: o_result = i_rdata;
        endcase
    end

endmodule : load_extract
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory-access stage of the 5-stage in-order pipeline.
//                Holds the EX->MEM pipeline register, waits for the data-SRAM
//                response of an issued load/store, extracts load data and
//                drives the MEM->WB bus plus a forwarding bus back to ID.
//  Ports       : clk, reset              - clock / sync active-high reset
//                EX_to_MEM_BUS/_valid    - upstream instruction
//                MEM_allowin             - stage can accept this cycle
//                MEM_to_WB_BUS/_valid    - downstream instruction
//                WB_allowin              - WB can accept
//                data_sram_data_ok/rdata - response of oldest request
//                flush                   - kill stage content (exception/ertn)
//                MEM_FWD_BUS             - {dest, is_load, data_pending, result}
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int CSR_W = mem_stage_pkg::CSR_W,
    parameter int EM_W  = 75 + CSR_W,
    parameter int MW_W  = 103 + CSR_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [EM_W-1:0]                 EX_to_MEM_BUS,
    input  logic                            EX_to_MEM_valid,
    output logic                            MEM_allowin,
    output logic [MW_W-1:0]                 MEM_to_WB_BUS,
    output logic                            MEM_to_WB_valid,
    input  logic                            WB_allowin,
    input  logic                            data_sram_data_ok,
    input  logic [31:0]                     data_sram_rdata,
    input  logic                            flush,
    output logic [mem_stage_pkg::FWD_W-1:0] MEM_FWD_BUS
);

    import mem_stage_pkg::*;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            r_mem_valid;
    logic [EM_W-1:0] r_bus;
    logic            r_resp_buf_valid;
    logic [31:0]     r_resp_buf;
    logic            r_discard_pending;

    // ------------------------------------------------------------------
    // Pipeline register fields
    // ------------------------------------------------------------------
    logic [CSR_W-1:0] w_csr;
    logic             w_mem_req;
    logic             w_rfrom_mem;
    logic [2:0]       w_load_op;
    logic [31:0]      w_alu_result;
    logic [4:0]       w_dest;
    logic             w_gr_we;
    logic [31:0]      w_pc;

    assign w_csr        = r_bus[CSR_W-1:0];
    assign w_mem_req    = r_bus[CSR_W + EM_MEM_REQ];
    assign w_rfrom_mem  = r_bus[CSR_W + EM_RFROM];
    assign w_load_op    = r_bus[CSR_W + EM_LOAD_OP +: 3];
    assign w_alu_result = r_bus[CSR_W + EM_ALU +: 32];
    assign w_dest       = r_bus[CSR_W + EM_DEST +: 5];
    assign w_gr_we      = r_bus[CSR_W + EM_GR_WE];
    assign w_pc         = r_bus[CSR_W + EM_PC +: 32];

    // ------------------------------------------------------------------
    // Response tracking
    // ------------------------------------------------------------------
    logic w_own_ok;       // data_ok belongs to the instruction held here
    logic w_ready_go;
    logic w_leave;        // instruction transfers to WB at this edge
    logic w_capture;      // response arrived but instruction stays: buffer it
    logic w_discard_set;  // flushed with its response still in flight

    // A data_ok seen while a flushed request is still outstanding is that
    // request's answer, never the current instruction's.
    assign w_own_ok   = data_sram_data_ok && !r_discard_pending;
    assign w_ready_go = !w_mem_req || r_resp_buf_valid || w_own_ok;

    assign MEM_to_WB_valid = r_mem_valid && w_ready_go && !flush;
    assign MEM_allowin     = !r_mem_valid || (w_ready_go && WB_allowin);
    assign w_leave         = MEM_to_WB_valid && WB_allowin;

    assign w_capture = r_mem_valid && w_mem_req && !r_resp_buf_valid
                       && w_own_ok && !w_leave && !flush;

    // A response arriving in the flush cycle is consumed by that cycle, so
    // only a request with no response yet leaves an orphan behind.
    assign w_discard_set = flush && r_mem_valid && w_mem_req
                           && !r_resp_buf_valid && !w_own_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_valid       <= 1'b0;
            r_bus             <= '0;
            r_resp_buf_valid  <= 1'b0;
            r_resp_buf        <= 32'h0;
            r_discard_pending <= 1'b0;
        end else begin
            // flush wins over a simultaneous accept
            if (flush) begin
                r_mem_valid <= 1'b0;
            end else if (MEM_allowin) begin
                r_mem_valid <= EX_to_MEM_valid;
            end

            if (EX_to_MEM_valid && MEM_allowin) begin
                r_bus <= EX_to_MEM_BUS;
            end

            if (flush || w_leave) begin
                r_resp_buf_valid <= 1'b0;
            end else if (w_capture) begin
                r_resp_buf_valid <= 1'b1;
                r_resp_buf       <= data_sram_rdata;
            end

            // Setting takes precedence: an orphan's data_ok may clear the old
            // flag in the same cycle a new in-flight request gets flushed.
            if (w_discard_set) begin
                r_discard_pending <= 1'b1;
            end else if (data_sram_data_ok) begin
                r_discard_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load data
    // ------------------------------------------------------------------
    logic [31:0] w_load_data;
    logic [31:0] w_extracted;
    logic [31:0] w_mem_result;
    logic [31:0] w_fwd_result;
    logic        w_data_pending;

    assign w_load_data = r_resp_buf_valid ? r_resp_buf : data_sram_rdata;

    load_extract u_load_extract (
        .i_load_op (w_load_op),
        .i_addr_lo (w_alu_result[1:0]),
        .i_rdata   (w_load_data),
        .o_result  (w_extracted)
    );

    assign w_mem_result = w_rfrom_mem ? w_extracted : 32'h0;

    assign MEM_to_WB_BUS = {w_pc, w_gr_we, w_dest, w_mem_result,
                            w_alu_result, w_rfrom_mem, w_csr};

    // ------------------------------------------------------------------
    // Forwarding to ID
    // ------------------------------------------------------------------
    assign w_fwd_result   = w_rfrom_mem ? w_mem_result : w_alu_result;
    assign w_data_pending = r_mem_valid && w_rfrom_mem && !w_ready_go;

    assign MEM_FWD_BUS[FWD_DEST +: 5]  = (r_mem_valid && w_gr_we) ? w_dest : 5'd0;
    assign MEM_FWD_BUS[FWD_IS_LOAD]    = r_mem_valid && w_rfrom_mem;
    assign MEM_FWD_BUS[FWD_PENDING]    = w_data_pending;
    assign MEM_FWD_BUS[31:0]           = w_fwd_result;

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Scoreboard testbench for mem_stage. Accepted instructions
//                push their expected WB bus into a queue; a monitor pops and
//                compares on every WB transfer. A simple in-order memory
//                model answers requests after a chosen delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int CSR_W = 79;
    localparam int EM_W  = 75 + CSR_W;
    localparam int MW_W  = 103 + CSR_W;
    localparam int QN    = 1024;

    logic            clk = 1'b0;
    logic            reset;
    logic [EM_W-1:0] EX_to_MEM_BUS;
    logic            EX_to_MEM_valid;
    logic            MEM_allowin;
    logic [MW_W-1:0] MEM_to_WB_BUS;
    logic            MEM_to_WB_valid;
    logic            WB_allowin;
    logic            data_sram_data_ok;
    logic [31:0]     data_sram_rdata;
    logic            flush;
    logic [38:0]     MEM_FWD_BUS;

    int checks = 0;
    int errors = 0;

    // expected WB transfers (written by main, consumed by monitor)
    logic [MW_W-1:0] exp_bus  [QN];
    bit              exp_kill [QN];
    int              exp_wr = 0;
    int              exp_rd = 0;

    // memory responses in request order (written by main, served by env)
    logic [31:0] mem_dat [QN];
    int          mem_dly [QN];
    int          mem_wr = 0;
    int          mem_rd = 0;

    bit mem_clear = 1'b0;
    bit wb_rand   = 1'b0;
    bit wb_fixed  = 1'b1;
    int pc_ctr    = 32'h1c00_0000;

    mem_stage #(.CSR_W(CSR_W), .EM_W(EM_W), .MW_W(MW_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .EX_to_MEM_BUS     (EX_to_MEM_BUS),
        .EX_to_MEM_valid   (EX_to_MEM_valid),
        .MEM_allowin       (MEM_allowin),
        .MEM_to_WB_BUS     (MEM_to_WB_BUS),
        .MEM_to_WB_valid   (MEM_to_WB_valid),
        .WB_allowin        (WB_allowin),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .flush             (flush),
        .MEM_FWD_BUS       (MEM_FWD_BUS)
    );

    always #5 clk = ~clk;

    // Reference load semantics from plain shifts and masks
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * a)) & 32'h0000_00FF;
        h = (d >> (16 * a[1])) & 32'h0000_FFFF;
        case (op)
            3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd3:    return b;
            3'd4:    return h;
            default: return d;
        endcase
    endfunction

    function automatic int pending_count();
        int c;
        c = 0;
        for (int j = exp_rd; j < exp_wr; j++) begin
            if (!exp_kill[j % QN]) c++;
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory / WB environment (drives at posedge+2)
    // ------------------------------------------------------------------
    initial begin : env
        int cnt;
        bit have;
        cnt = 0;
        have = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        WB_allowin        = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = $urandom;
            WB_allowin        = wb_rand ? ($urandom_range(0, 3) != 0) : wb_fixed;
            if (mem_clear) begin
                mem_rd = mem_wr;
                have   = 1'b0;
            end else if (mem_rd != mem_wr) begin
                if (!have) begin
                    cnt  = mem_dly[mem_rd % QN];
                    have = 1'b1;
                end
                if (cnt == 0) begin
                    data_sram_data_ok = 1'b1;
                    data_sram_rdata   = mem_dat[mem_rd % QN];
                    mem_rd++;
                    have = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compare every WB transfer against the scoreboard
    // ------------------------------------------------------------------
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset && MEM_to_WB_valid && WB_allowin) begin
                while (exp_rd < exp_wr && exp_kill[exp_rd % QN]) exp_rd++;
                checks++;
                if (exp_rd >= exp_wr) begin
                    errors++;
                    $display("FAIL wb_unexpected got %h want no transfer", MEM_to_WB_BUS);
                end else begin
                    if (MEM_to_WB_BUS !== exp_bus[exp_rd % QN]) begin
                        errors++;
                        $display("FAIL wb_bus got %h want %h", MEM_to_WB_BUS,
                                 exp_bus[exp_rd % QN]);
                    end
                    exp_rd++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus tasks (all start and end at posedge+1)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] alu, input logic [2:0] op, input bit rfrom,
                         input bit mreq, input logic [31:0] rd, input int dly);
        logic [95:0]      rnd;
        logic [CSR_W-1:0] csr;
        logic [4:0]       dest;
        logic             gr_we;
        logic [31:0]      mres;
        logic [31:0]      pc;
        bit               accepted;
        rnd      = {$urandom, $urandom, $urandom};
        csr      = rnd[CSR_W-1:0];
        dest     = 5'($urandom);
        gr_we    = 1'($urandom);
        pc       = pc_ctr;
        pc_ctr   = pc_ctr + 4;
        mres     = rfrom ? ref_load(op, alu[1:0], rd) : 32'h0;
        accepted = 1'b0;
        EX_to_MEM_BUS   = {pc, gr_we, dest, alu, op, rfrom, mreq, csr};
        EX_to_MEM_valid = 1'b1;
        for (int t = 0; t <= 40; t++) begin
            @(negedge clk);
            if (MEM_allowin) begin
                exp_bus[exp_wr % QN]  = {pc, gr_we, dest, mres, alu, rfrom, csr};
                exp_kill[exp_wr % QN] = 1'b0;
                exp_wr++;
                if (mreq) begin
                    mem_dat[mem_wr % QN] = rd;
                    mem_dly[mem_wr % QN] = dly;
                    mem_wr++;
                end
                accepted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got allowin=0 want allowin=1");
        end
        @(posedge clk);
        #1;
        EX_to_MEM_valid = 1'b0;
    endtask

    task automatic issue_random();
        int          kind;
        logic [2:0]  op;
        logic [31:0] a;
        kind = $urandom_range(0, 2);
        op   = 3'($urandom_range(0, 7));
        a    = $urandom;
        if (kind == 1) begin
            if (op == 3'd1 || op == 3'd4) a[0] = 1'b0;
            else if (op != 3'd0 && op != 3'd3) a[1:0] = 2'b00;
        end
        issue(a, op, kind == 1, kind != 0, $urandom, $urandom_range(0, 4));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        if (exp_wr - 1 >= exp_rd) exp_kill[(exp_wr - 1) % QN] = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        mem_clear = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_clear = 1'b0;
        for (int j = exp_rd; j < exp_wr; j++) exp_kill[j % QN] = 1'b1;
    endtask

    task automatic check_idle_state(input string tag);
        @(negedge clk);
        chk({tag, "_wb_valid"}, 32'(MEM_to_WB_valid), 32'd0);
        chk({tag, "_allowin"},  32'(MEM_allowin), 32'd1);
        chk({tag, "_fwd_dest"}, 32'(MEM_FWD_BUS[38:34]), 32'd0);
        chk({tag, "_pending"},  32'(MEM_FWD_BUS[32]), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 200 && pending_count() > 0; t++) @(posedge clk);
        #1;
        chk({tag, "_remaining"}, 32'(pending_count()), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : main
        reset           = 1'b1;
        flush           = 1'b0;
        EX_to_MEM_valid = 1'b0;
        EX_to_MEM_BUS   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_state("reset");

        // ALU op passes straight through
        issue(32'h0000_1234, 3'd2, 1'b0, 1'b0, 32'h0, 0);

        // LB from byte 3, response two cycles late
        issue(32'h0000_2003, 3'd0, 1'b1, 1'b1, 32'h80FF_0000, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lb_data_pending", 32'(MEM_FWD_BUS[32]), (i < 2) ? 32'd1 : 32'd0);
            if (i == 2) chk("lb_fwd_result", MEM_FWD_BUS[31:0], 32'hFFFF_FF80);
        end
        @(posedge clk);
        #1;

        // LHU upper half, LH lower half
        issue(32'h0000_3002, 3'd4, 1'b1, 1'b1, 32'hBEEF_1234, 1);
        issue(32'h0000_3000, 3'd1, 1'b1, 1'b1, 32'hBEEF_1234, 0);
        idle(4);

        // LW response arrives while WB is blocked: held, stage stays closed
        wb_fixed = 1'b0;
        issue(32'h0000_4000, 3'd2, 1'b1, 1'b1, 32'hCAFE_F00D, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lw_hold_allowin", 32'(MEM_allowin), 32'd0);
        end
        @(posedge clk);
        #1;
        wb_fixed = 1'b1;
        idle(3);

        // Flushed LW: its late response must not reach the next LW
        issue(32'h0000_5000, 3'd2, 1'b1, 1'b1, 32'h1111_1111, 3);
        do_flush();
        issue(32'h0000_5004, 3'd2, 1'b1, 1'b1, 32'h2222_2222, 0);
        drain("flush_seq");

        // Randomized traffic with random WB back-pressure and flushes
        wb_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r == 0 && (mem_wr - mem_rd) <= 1) do_flush();
            else if (r < 3) idle(1);
            else issue_random();
        end
        wb_rand = 1'b0;
        idle(2);
        drain("random");

        // Reset while a load is waiting
        issue(32'h0000_6000, 3'd2, 1'b1, 1'b1, 32'h3333_3333, 6);
        idle(1);
        do_reset(1);
        check_idle_state("midreset");
        issue(32'h0000_6005, 3'd3, 1'b1, 1'b1, 32'h4455_6677, 1);
        drain("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_stage
`default_nettype wire
